// File: rtl/rd_burst_control.sv
// rd_burst_control: read burst engine that moves one SDRAM read burst into the read FIFO
// Ports: scheduler command (rd_req, rd_burst_length, rd_burst_address, rd_burst_ack),
//   SDRAM arbitration (hold, holda) with latched burst_length/burst_address,
//   read return (rd_data, rd_valid), FIFO write side (fifo_wen, fifo_wdata, fifo_afull, fifo_full),
//   status (busy, sticky error).
module rd_burst_control #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 9,
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [LEN_WIDTH-1:0]  rd_burst_length,
    input  logic [ADDR_WIDTH-1:0] rd_burst_address,
    output logic                  rd_burst_ack,
    output logic                  hold,
    input  logic                  holda,
    output logic [LEN_WIDTH-1:0]  burst_length,
    output logic [ADDR_WIDTH-1:0] burst_address,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic                  fifo_wen,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_afull,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic                  error
);
    typedef enum logic [2:0] {IDLE = 3'h1, REQ = 3'h2, BURST = 3'h4} state_t;
    state_t                state_q;
    logic [LEN_WIDTH-1:0]  remaining_q, burst_length_q;
    logic [ADDR_WIDTH-1:0] burst_address_q;
    logic [DATA_WIDTH-1:0] fifo_wdata_q;
    logic                  ack_q, hold_q, fifo_wen_q, busy_q, error_q;
    logic                  last_word;
    assign last_word = rd_valid && remaining_q == LEN_WIDTH'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            burst_length_q  <= '0;
            burst_address_q <= '0;
            fifo_wdata_q    <= '0;
            ack_q           <= 1'b0;
            hold_q          <= 1'b0;
            fifo_wen_q      <= 1'b0;
            busy_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            ack_q      <= 1'b0;
            fifo_wen_q <= 1'b0;
            if ((rd_valid && state_q != BURST) || (fifo_wen_q && fifo_full))
                error_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    // ack_q blocks a second ack while rd_req is still held through the ack cycle
                    if (rd_req && !fifo_afull && !ack_q) begin
                        ack_q <= 1'b1;
                        if (rd_burst_length != '0) begin
                            burst_length_q  <= rd_burst_length;
                            burst_address_q <= rd_burst_address;
                            remaining_q     <= rd_burst_length;
                            state_q         <= REQ;
                            busy_q          <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    hold_q <= 1'b1;
                    if (holda)
                        state_q <= BURST;
                end
                BURST: begin
                    if (rd_valid) begin
                        fifo_wen_q   <= 1'b1;
                        fifo_wdata_q <= rd_data;
                    end
                    // the final word wins over a simultaneous grant loss
                    if (last_word || !holda) begin
                        state_q <= IDLE;
                        hold_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        if (!last_word)
                            error_q <= 1'b1;
                    end else if (rd_valid) begin
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    hold_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
    assign rd_burst_ack  = ack_q;
    assign hold          = hold_q;
    assign burst_length  = burst_length_q;
    assign burst_address = burst_address_q;
    assign fifo_wen      = fifo_wen_q;
    assign fifo_wdata    = fifo_wdata_q;
    assign busy          = busy_q;
    assign error         = error_q;
endmodule

// File: tb/tb_rd_burst_control.sv
// tb_rd_burst_control: randomized and directed bench with a transaction-level burst model
module tb_rd_burst_control;
    logic        clk = 1'b0;
    logic        rst, rd_req, holda, rd_valid, fifo_afull, fifo_full;
    logic [8:0]  rd_burst_length;
    logic [21:0] rd_burst_address;
    logic [15:0] rd_data;
    logic        rd_burst_ack, hold, fifo_wen, busy, error;
    logic [8:0]  burst_length;
    logic [21:0] burst_address;
    logic [15:0] fifo_wdata;
    int          checks = 0, failures = 0, ack_cnt = 0;
    bit          err_exp = 1'b0;
    logic [15:0] exp_q[$];

    rd_burst_control dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_burst_length(rd_burst_length),
        .rd_burst_address(rd_burst_address), .rd_burst_ack(rd_burst_ack), .hold(hold),
        .holda(holda), .burst_length(burst_length), .burst_address(burst_address),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
        .fifo_afull(fifo_afull), .fifo_full(fifo_full), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // every FIFO write must match the oldest word the model expects
    always @(negedge clk) begin
        if (rd_burst_ack) ack_cnt++;
        if (fifo_wen) begin
            if (exp_q.size() == 0) check("wen_extra", 1, 0);
            else check("wdata", fifo_wdata, exp_q.pop_front());
        end
    end

    task automatic do_reset();
        rst = 1; rd_req = 0; rd_valid = 0; holda = 0; fifo_afull = 0; fifo_full = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        check("q_drain", exp_q.size(), 0);
        exp_q.delete();
        err_exp = 0;
        check("rst_hold", hold, 0);
        check("rst_ack", rd_burst_ack, 0);
        check("rst_blen", burst_length, 0);
        check("rst_baddr", burst_address, 0);
        check("rst_wen", fifo_wen, 0);
        check("rst_wdata", fifo_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        @(negedge clk);
    endtask

    // mode: 0 normal, 1 holda lost before word 'at', 2 reset before word 'at'
    task automatic run_burst(input int len, input logic [21:0] addr, input int hd,
                             input int gmin, input int gmax, input int mode, input int at,
                             input bit fall_last, input bit pat);
        int acks0, n;
        logic [15:0] d;
        acks0 = ack_cnt;
        rd_req = 1; rd_burst_length = len[8:0]; rd_burst_address = addr;
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_burst_ack && n < 50);
        check("ack_seen", rd_burst_ack, 1);
        rd_req = 0;
        check("blen", burst_length, len[8:0]);
        check("baddr", burst_address, addr);
        n = 0;
        while (!hold && n < 50) begin @(negedge clk); n++; end
        check("hold_up", hold, 1);
        repeat (hd) @(negedge clk);
        holda = 1;
        @(negedge clk);
        check("busy_burst", busy, 1);
        for (int i = 0; i < len; i++) begin
            if (mode == 1 && i == at) begin
                rd_valid = 0; holda = 0;
                err_exp = 1;
                @(negedge clk);
                check("drop_err", error, 1);
                check("drop_hold", hold, 0);
                check("drop_busy", busy, 0);
                @(negedge clk);
                check("drop_q", exp_q.size(), 0);
                check("ack_once", ack_cnt - acks0, 1);
                return;
            end
            if (mode == 2 && i == at) begin
                rst = 1; rd_valid = 1; rd_data = 16'($urandom);
                @(negedge clk);
                check("mrst_hold", hold, 0);
                check("mrst_busy", busy, 0);
                check("mrst_wen", fifo_wen, 0);
                check("mrst_blen", burst_length, 0);
                check("mrst_error", error, 0);
                repeat (2) begin
                    rd_data = 16'($urandom);
                    @(negedge clk);
                    check("mrst_nowen", fifo_wen, 0);
                end
                rst = 0; rd_valid = 0; holda = 0; err_exp = 0;
                @(negedge clk);
                check("mrst_q", exp_q.size(), 0);
                return;
            end
            repeat ($urandom_range(gmax, gmin)) begin rd_valid = 0; @(negedge clk); end
            d = pat ? 16'((i + 1) * 16'h1111) : 16'($urandom);
            rd_valid = 1; rd_data = d;
            exp_q.push_back(d);
            if (i == len - 1 && fall_last) holda = 0;
            @(negedge clk);
            if (i < len - 1) check("busy_mid", busy, 1);
        end
        rd_valid = 0;
        check("end_hold", hold, 0);
        check("end_busy", busy, 0);
        check("end_blen", burst_length, len[8:0]);
        holda = 0;
        @(negedge clk);
        check("end_q", exp_q.size(), 0);
        check("end_error", error, err_exp);
        check("ack_once", ack_cnt - acks0, 1);
    endtask

    initial begin
        rst = 1; rd_req = 0; holda = 0; rd_valid = 0; fifo_afull = 0; fifo_full = 0;
        rd_burst_length = 0; rd_burst_address = 0; rd_data = 0;
        @(negedge clk);
        do_reset();
        run_burst(8, 22'h000100, 3, 0, 0, 0, 0, 0, 1);
        run_burst(8, 22'h000100, 1, 1, 1, 0, 0, 0, 1);
        // almost-full blocks acceptance; zero-length command acks but latches nothing
        fifo_afull = 1; rd_req = 1; rd_burst_length = 0; rd_burst_address = 22'h3ABCDE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("afull_ack", rd_burst_ack, 0);
            check("afull_hold", hold, 0);
        end
        fifo_afull = 0;
        @(negedge clk);
        check("afull_release_ack", rd_burst_ack, 1);
        rd_req = 0;
        @(negedge clk);
        check("len0_ack_once", rd_burst_ack, 0);
        check("len0_busy", busy, 0);
        check("len0_blen", burst_length, 8);
        check("len0_baddr", burst_address, 22'h000100);
        run_burst(4, 22'h001234, 1, 0, 0, 1, 2, 0, 0);
        repeat (3) @(negedge clk);
        check("err_sticky", error, 1);
        do_reset();
        rd_valid = 1; rd_data = 16'hDEAD;
        @(negedge clk);
        rd_valid = 0;
        check("idle_valid_wen", fifo_wen, 0);
        check("idle_valid_err", error, 1);
        do_reset();
        run_burst(8, 22'h000200, 2, 0, 0, 2, 3, 0, 1);
        do_reset();
        fifo_full = 1; err_exp = 1;
        run_burst(3, 22'h000300, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        run_burst(1, 22'h3FFFFF, 0, 0, 0, 0, 0, 1, 0);
        run_burst(511, 22'h155555, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++)
            run_burst($urandom_range(16, 1), 22'($urandom), $urandom_range(4, 0), 0,
                      $urandom_range(2, 0), 0, 0, 1'($urandom), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rd_burst_control.md
Name: rd_burst_control

Overview:
Read-direction burst engine; the counterpart of the write burst controller.
- Accepts a read-burst command (length, address) from the upstream scheduler.
- Arbitrates for the SDRAM controller with the hold/holda handshake.
- Collects the returned words and pushes each one into the downstream read FIFO.
- Sits between the burst scheduler and the SDRAM controller, on the same clk domain (100-133 MHz).

Parameters:
DATA_WIDTH, 16, SDRAM DQ width and read FIFO write width
LEN_WIDTH, 9, burst length counter width in words (legal lengths 1..2^LEN_WIDTH-1)
ADDR_WIDTH, 22, SDRAM burst start address width

Ports:
clk  in  1  system clock; every register updates on its rising edge
rst  in  1  reset, synchronous, active-high
rd_req  in  1  read-burst command pending, held high until acked
rd_burst_length  in  LEN_WIDTH  requested burst length in words
rd_burst_address  in  ADDR_WIDTH  requested start address
rd_burst_ack  out  1  one-cycle pulse; command latched
hold  out  1  bus request to the SDRAM controller
holda  in  1  bus grant from the SDRAM controller
burst_length  out  LEN_WIDTH  latched length presented to the controller
burst_address  out  ADDR_WIDTH  latched address presented to the controller
rd_data  in  DATA_WIDTH  read word from the controller
rd_valid  in  1  rd_data valid this cycle
fifo_wen  out  1  read FIFO write enable
fifo_wdata  out  DATA_WIDTH  read FIFO write data
fifo_afull  in  1  read FIFO almost full; must leave room for one full burst
fifo_full  in  1  read FIFO full
busy  out  1  high when the state is not IDLE
error  out  1  sticky protocol-error flag

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; all outputs 0, including hold, ack, burst_length, burst_address, fifo_wen, fifo_wdata, error; remaining counter=0. Reset mid-burst drops hold the same edge; any words still arriving are ignored and do not set error.
- State machine, one-hot encoding: IDLE=3'h1, REQ=3'h2, BURST=3'h4; any other code returns to IDLE.
- IDLE, rd_req=1, fifo_afull=0, rd_burst_length!=0:
  - latch burst_length and burst_address;
  - remaining <= rd_burst_length;
  - rd_burst_ack pulses for 1 cycle;
  - next state REQ.
- IDLE, rd_req=1 with rd_burst_length=0: ack pulses, nothing is latched, stay IDLE.
- IDLE, fifo_afull=1: command is not accepted, no ack, stay IDLE.
- REQ: hold=1 (registered; rises the cycle after entering REQ). When holda=1, go to BURST. No timeout; REQ waits indefinitely.
- BURST: hold stays 1. On each rd_valid=1:
  - fifo_wen=1 and fifo_wdata=rd_data on the next cycle (1-cycle registered latency);
  - remaining decrements.
- End of burst: rd_valid with remaining==1 moves to IDLE. hold=0 from that next cycle. The last fifo_wen occurs in the first IDLE cycle.
- rd_ack pulses at most once per command. rd_req must stay high through the ack cycle; the scheduler drops or updates it after the ack.
- A new command may be accepted on the first IDLE cycle after the burst. Back-to-back bursts keep a minimum gap of 1 IDLE cycle with hold=0.
- burst_length and burst_address stay stable from REQ until the return to IDLE.
- error is set (and held until rst) on any of:
  - rd_valid while the state is not BURST;
  - holda falling in BURST before the last word. The state then goes to IDLE, hold drops, and the partial data stays in the FIFO;
  - fifo_wen asserted while fifo_full=1. The write is still issued, and the FIFO drops it.
- Simultaneous holda fall and final rd_valid in the same cycle: the word is written, no error, normal exit.
- Counter arithmetic is unsigned and modulo 2^LEN_WIDTH. It never decrements below 1 inside BURST.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset, then rd_req=1, length=8, addr=0x000100, holda returns 3 cycles after hold, rd_valid for 8 consecutive cycles with data 0x1111..0x8888 -> ack pulses exactly once; burst_address=0x000100; 8 fifo_wen pulses with data in order, each 1 cycle after its rd_valid; hold falls after the 8th word; error=0.
- Same command, but rd_valid gapped (valid every other cycle) -> still exactly 8 writes; state stays BURST until the 8th; no error.
- fifo_afull=1 with rd_req=1 for 10 cycles, then afull=0 -> no ack and no hold while afull is high; ack the cycle after afull falls.
- length=4, holda drops after 2 words -> 2 FIFO writes, error=1, return to IDLE, hold=0; error persists until rst.
- rd_valid pulse while IDLE -> error=1, no fifo_wen.
- rst asserted in BURST after 3 of 8 words -> next cycle hold=0, state IDLE, all outputs 0; remaining rd_valid pulses during rst produce no writes.
